// File: rtl/case_9_sdiv_16s_8s_16_seq.sv
// Sequential signed divider: radix-2 restoring division producing one
// quotient bit per enabled clock, driven through a start/done handshake
// with a clock-enable stall. The quotient truncates toward zero and the
// remainder takes the sign of the dividend.
module case_9_sdiv_16s_8s_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem
);

    // Iteration counter must hold the value din0_WIDTH itself.
    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [din0_WIDTH-1:0] ONE0     = {{(din0_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [din1_WIDTH-1:0] ONE1     = {{(din1_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(din0_WIDTH);

    // Reject parameter sets the datapath cannot represent.
    generate
        if ((ID < 0) || (dout_WIDTH != din0_WIDTH) || (din0_WIDTH < 2) ||
            (din1_WIDTH < 2) || (din1_WIDTH > din0_WIDTH)) begin : g_bad_params
            $error("case_9_sdiv_16s_8s_16_seq: unsupported parameter combination");
        end
    endgenerate

    // Two's-complement negation at dividend/quotient width.
    function automatic logic [din0_WIDTH-1:0] neg0(input logic [din0_WIDTH-1:0] v);
        return (~v) + ONE0;
    endfunction

    // Two's-complement negation at divisor/remainder width.
    function automatic logic [din1_WIDTH-1:0] neg1(input logic [din1_WIDTH-1:0] v);
        return (~v) + ONE1;
    endfunction

    // Magnitudes are kept unsigned at full width so |most-negative| fits.
    function automatic logic [din0_WIDTH-1:0] mag0(input logic [din0_WIDTH-1:0] v);
        return v[din0_WIDTH-1] ? neg0(v) : v;
    endfunction

    function automatic logic [din1_WIDTH-1:0] mag1(input logic [din1_WIDTH-1:0] v);
        return v[din1_WIDTH-1] ? neg1(v) : v;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  negq_q,  negq_d;   // quotient must be negated
    logic                  negr_q,  negr_d;   // remainder must be negated
    logic [din1_WIDTH-1:0] prem_q,  prem_d;   // partial remainder
    logic [din0_WIDTH-1:0] quo_q,   quo_d;    // dividend magnitude / quotient bits
    logic [din1_WIDTH-1:0] dmag_q,  dmag_d;   // divisor magnitude
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic [dout_WIDTH-1:0] dout_q,  dout_d;
    logic [din1_WIDTH-1:0] rem_q,   rem_d;

    // The partial remainder stays below the divisor magnitude, so it fits
    // in din1_WIDTH bits; after the shift it needs one more, and the trial
    // difference carries an extra bit that acts as the borrow flag.
    logic [din1_WIDTH:0]   shift_s;
    logic [din1_WIDTH+1:0] trial_s;

    assign shift_s = {prem_q, quo_q[din0_WIDTH-1]};
    assign trial_s = {1'b0, shift_s} - {2'b00, dmag_q};

    // Next-state and datapath logic; every update is gated by ce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dmag_d  = dmag_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        negq_d  = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        negr_d  = din0[din0_WIDTH-1];
                        quo_d   = mag0(din0);
                        dmag_d  = mag1(din1);
                        prem_d  = '0;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (trial_s[din1_WIDTH+1]) begin
                        // Borrow: restore the shifted remainder, quotient bit 0.
                        prem_d = din1_WIDTH'(shift_s);
                        quo_d  = {quo_q[din0_WIDTH-2:0], 1'b0};
                    end else begin
                        prem_d = din1_WIDTH'(trial_s);
                        quo_d  = {quo_q[din0_WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    dout_d  = negq_q ? neg0(quo_q) : quo_q;
                    rem_d   = negr_q ? neg1(prem_q) : prem_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            prem_q  <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dmag_q  <= dmag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_case_9_sdiv_16s_8s_16_seq.sv
// Directed-vector bench for the sequential signed divider.
module tb_case_9_sdiv_16s_8s_16_seq;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ce       = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] din0     = 16'd0;
    logic [7:0]  din1     = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [7:0]  rem;

    int n_checks = 0;
    int n_fail   = 0;

    case_9_sdiv_16s_8s_16_seq #(
        .ID(1), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .dout(dout), .rem(rem)
    );

    always #5 ap_clk = ~ap_clk;

    // Launch one division from an idle cycle and wait (bounded) for done.
    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [63:0] stall_mask, input int pulse_at,
                          output int lat, output logic [15:0] q, output logic [7:0] r,
                          output bit busy_ok, output bit held_ok);
        logic [15:0] prev_q;
        logic [7:0]  prev_r;
        int          cyc;
        prev_q  = dout;
        prev_r  = rem;
        lat     = -1;
        q       = 16'd0;
        r       = 8'd0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        din0  = a;
        din1  = b;
        start = 1'b1;
        ce    = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (lat < 0 && cyc <= 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = cyc;
                q   = dout;
                r   = rem;
            end else begin
                if (dout !== prev_q || rem !== prev_r) held_ok = 1'b0;
                ce = ~stall_mask[cyc];
                if (cyc == pulse_at) begin
                    din0  = 16'd50;
                    din1  = 8'd5;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge ap_clk); #1;
                cyc++;
            end
        end
        ce    = 1'b1;
        start = 1'b0;
    endtask

    // One unstalled division with full result/latency/handshake checks.
    task automatic test_vector(input string name, input logic [15:0] a, input logic [7:0] b,
                               input logic [15:0] eq, input logic [7:0] er);
        int          lat;
        logic [15:0] q;
        logic [7:0]  r;
        bit          bok, hok;
        run_op(a, b, 64'd0, 0, lat, q, r, bok, hok);
        n_checks++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 18", name, lat);
        end
        n_checks++;
        if (q !== eq) begin
            n_fail++;
            $display("FAIL %s dout: got %h expected %h", name, q, eq);
        end
        n_checks++;
        if (r !== er) begin
            n_fail++;
            $display("FAIL %s rem: got %h expected %h", name, r, er);
        end
        n_checks++;
        if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_run: got 0 expected 1 through done", name);
        end
        n_checks++;
        if (hok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_hold: got change expected hold before done", name);
        end
        @(posedge ap_clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ce       = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 16'd0 || rem !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dout=%h rem=%h expected 0 0 0000 00",
                     busy, done, dout, rem);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_basic();
        test_vector("basic_100_7", 16'd100, 8'd7, 16'd14, 8'd2);
    endtask

    task automatic test_signs();
        test_vector("neg_100_7",     16'hFF9C, 8'd7,    16'hFFF2, 8'hFE);
        test_vector("100_neg_7",     16'd100,  8'hF9,   16'hFFF2, 8'd2);
        test_vector("neg_100_neg_7", 16'hFF9C, 8'hF9,   16'd14,   8'hFE);
    endtask

    task automatic test_extremes();
        test_vector("min_by_neg1",   16'h8000, 8'hFF, 16'h8000, 8'd0);
        test_vector("min_by_min",    16'h8000, 8'h80, 16'd256,  8'd0);
        test_vector("max_by_min",    16'h7FFF, 8'h80, 16'hFF01, 8'd127);
    endtask

    task automatic test_div_zero();
        test_vector("1234_by_zero",  16'd1234, 8'd0, 16'hFFFF, 8'hD2);
        test_vector("neg5_by_zero",  16'hFFFB, 8'd0, 16'd1,    8'hFB);
    endtask

    // Second start lands in the idle cycle right after done.
    task automatic test_back_to_back();
        test_vector("b2b_first",  16'd100, 8'd7, 16'd14, 8'd2);
        test_vector("b2b_second", 16'd50,  8'd5, 16'd10, 8'd0);
    endtask

    // Five ce-low cycles during CALC plus a start pulse while busy.
    task automatic test_stall_ignore();
        int          lat;
        logic [15:0] q;
        logic [7:0]  r;
        bit          bok, hok;
        run_op(16'd100, 8'd7, 64'h0000_0000_0000_1268, 7, lat, q, r, bok, hok);
        n_checks++;
        if (lat !== 23) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 23", lat);
        end
        n_checks++;
        if (q !== 16'd14 || r !== 8'd2) begin
            n_fail++;
            $display("FAIL stall_result: got dout=%h rem=%h expected 000e 02", q, r);
        end
        n_checks++;
        if (bok !== 1'b1 || hok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_handshake: got busy_ok=%b held_ok=%b expected 1 1", bok, hok);
        end
        @(posedge ap_clk); #1;
    endtask

    // ce low in the done cycle must keep done asserted.
    task automatic test_done_hold();
        int          lat;
        logic [15:0] q;
        logic [7:0]  r;
        bit          bok, hok;
        run_op(16'd100, 8'd7, 64'd0, 0, lat, q, r, bok, hok);
        ce = 1'b0;
        repeat (2) begin
            @(posedge ap_clk); #1;
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b1 || dout !== 16'd14) begin
                n_fail++;
                $display("FAIL done_hold: got done=%b busy=%b dout=%h expected 1 1 000e",
                         done, busy, dout);
            end
        end
        ce = 1'b1;
        @(posedge ap_clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_release: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        din0  = 16'd100;
        din1  = 8'd7;
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge ap_clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy: got %b expected 1", busy);
        end
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 16'd0 || rem !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b dout=%h rem=%h expected 0 0 0000 00",
                     busy, done, dout, rem);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        test_vector("after_reset_9_3", 16'd9, 8'd3, 16'd3, 8'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_stall_ignore();
        test_done_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
